// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage types: handshake stage states and the LC-3b NOP encoding.
package pipe_stage_skid_pkg;

   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_BUSY  = 2'd1,
      PIPE_FULL  = 2'd2
   } lc3b_pipe_state;

   // BR with nzp=000 never branches, so an all-zero word is a harmless bubble.
   localparam logic [15:0] LC3B_NOP = 16'h0000;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter: +1 per cycle with inc high, holds at all-ones, cleared by rst.
// Latency: count reflects inc of the previous cycle; no backpressure.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with optional 2-entry skid, flush and stall/bubble counters.
// Latency 1 cycle; SKID=1 gives registered up_ready, SKID=0 passes dn_ready back combinationally.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned      WIDTH     = 16,
   parameter int unsigned      SKID      = 1,
   parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(LC3B_NOP),
   parameter int unsigned      PERF_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [WIDTH-1:0]  up_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [WIDTH-1:0]  dn_data,
   output logic [1:0]        occupancy,
   output logic [PERF_W-1:0] stall_cycles,
   output logic [PERF_W-1:0] bubble_cycles
);

   lc3b_pipe_state   state, state_nxt;
   logic [WIDTH-1:0] m_q, m_din;
   logic             m_ld;
   logic             up_xfer, dn_xfer;
   logic             stall_inc, bubble_inc;

   assign up_xfer  = up_valid & up_ready;
   assign dn_xfer  = dn_valid & dn_ready;
   assign dn_valid = (state != PIPE_EMPTY);
   assign dn_data  = dn_valid ? m_q : NOP_VALUE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PIPE_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_q <= NOP_VALUE;
      end else if (m_ld) begin
         m_q <= m_din;
      end
   end

   generate
      if (SKID != 0) begin : g_skid
         logic [WIDTH-1:0] s_q;
         logic             s_ld;
         logic             up_ready_q;

         always_comb begin
            state_nxt = state;
            m_ld      = 1'b0;
            m_din     = up_data;
            s_ld      = 1'b0;
            case (state)
               PIPE_EMPTY: begin
                  if (up_xfer) begin
                     state_nxt = PIPE_BUSY;
                     m_ld      = 1'b1;
                  end
               end
               PIPE_BUSY: begin
                  if (up_xfer && dn_xfer) begin
                     m_ld = 1'b1;
                  end else if (up_xfer) begin
                     state_nxt = PIPE_FULL;
                     s_ld      = 1'b1;
                  end else if (dn_xfer) begin
                     state_nxt = PIPE_EMPTY;
                  end
               end
               PIPE_FULL: begin
                  if (dn_xfer) begin
                     state_nxt = PIPE_BUSY;
                     m_ld      = 1'b1;
                     m_din     = s_q;
                  end
               end
               default: state_nxt = PIPE_EMPTY;
            endcase
            // A squash wins over every handshake; held payloads are simply abandoned.
            if (flush) begin
               state_nxt = PIPE_EMPTY;
               m_ld      = 1'b0;
               s_ld      = 1'b0;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               s_q <= NOP_VALUE;
            end else if (s_ld) begin
               s_q <= up_data;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               up_ready_q <= 1'b1;
            end else begin
               up_ready_q <= (state_nxt != PIPE_FULL);
            end
         end

         assign up_ready = up_ready_q;
      end else begin : g_noskid
         always_comb begin
            state_nxt = state;
            m_ld      = 1'b0;
            m_din     = up_data;
            case (state)
               PIPE_EMPTY: begin
                  if (up_xfer) begin
                     state_nxt = PIPE_BUSY;
                     m_ld      = 1'b1;
                  end
               end
               PIPE_BUSY: begin
                  if (up_xfer) begin
                     m_ld = 1'b1;
                  end else if (dn_xfer) begin
                     state_nxt = PIPE_EMPTY;
                  end
               end
               default: state_nxt = PIPE_EMPTY;
            endcase
            if (flush) begin
               state_nxt = PIPE_EMPTY;
               m_ld      = 1'b0;
            end
         end

         assign up_ready = dn_ready | ~dn_valid;
      end
   endgenerate

   always_comb begin
      occupancy = 2'd0;
      case (state)
         PIPE_BUSY: occupancy = 2'd1;
         PIPE_FULL: occupancy = 2'd2;
         default:   occupancy = 2'd0;
      endcase
   end

   assign stall_inc  = dn_valid & ~dn_ready;
   assign bubble_inc = ~dn_valid & dn_ready;

   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(PERF_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bubble_inc),
      .count (bubble_cycles)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (4-bit counters) and a no-skid instance share clk/rst.
module tb_pipe_stage_skid;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic        s_flush, s_up_valid, s_up_ready, s_dn_valid, s_dn_ready;
   logic [15:0] s_up_data, s_dn_data;
   logic [1:0]  s_occ;
   logic [3:0]  s_stall, s_bubble;

   logic        n_flush, n_up_valid, n_up_ready, n_dn_valid, n_dn_ready;
   logic [15:0] n_up_data, n_dn_data;
   logic [1:0]  n_occ;
   logic [15:0] n_stall, n_bubble;

   logic [15:0] q_s[$];
   logic [15:0] q_n[$];
   logic [15:0] exp_s, exp_n;
   logic        mon_n_en = 1'b0;
   int          n_delivered = 0;

   pipe_stage_skid #(.WIDTH(16), .SKID(1), .NOP_VALUE(16'h0000), .PERF_W(4)) u_skid (
      .clk(clk), .rst(rst), .flush(s_flush),
      .up_valid(s_up_valid), .up_ready(s_up_ready), .up_data(s_up_data),
      .dn_valid(s_dn_valid), .dn_ready(s_dn_ready), .dn_data(s_dn_data),
      .occupancy(s_occ), .stall_cycles(s_stall), .bubble_cycles(s_bubble)
   );

   pipe_stage_skid #(.WIDTH(16), .SKID(0), .NOP_VALUE(16'h0000), .PERF_W(16)) u_noskid (
      .clk(clk), .rst(rst), .flush(n_flush),
      .up_valid(n_up_valid), .up_ready(n_up_ready), .up_data(n_up_data),
      .dn_valid(n_dn_valid), .dn_ready(n_dn_ready), .dn_data(n_dn_data),
      .occupancy(n_occ), .stall_cycles(n_stall), .bubble_cycles(n_bubble)
   );

   // Scoreboard for the skid instance: push on accept, pop on delivery, drop all on flush/reset.
   always @(negedge clk) begin
      if (rst) begin
         q_s.delete();
      end else begin
         if (s_dn_valid && s_dn_ready) begin
            n_checks++;
            if (q_s.size() == 0) begin
               $display("FAIL sb_skid_unexpected: got %h, required no output", s_dn_data);
            end else begin
               exp_s = q_s.pop_front();
               if (s_dn_data !== exp_s)
                  $display("FAIL sb_skid_data: got %h, required %h", s_dn_data, exp_s);
               else
                  n_pass++;
            end
         end
         if (s_flush) q_s.delete();
         else if (s_up_valid && s_up_ready) q_s.push_back(s_up_data);
      end
   end

   always @(negedge clk) begin
      if (!rst && mon_n_en) begin
         n_checks++;
         if (n_up_ready !== (n_dn_ready | ~n_dn_valid))
            $display("FAIL noskid_up_ready: got %b, required %b", n_up_ready, n_dn_ready | ~n_dn_valid);
         else
            n_pass++;
         if (n_dn_valid && n_dn_ready) begin
            n_checks++;
            n_delivered++;
            if (q_n.size() == 0) begin
               $display("FAIL sb_noskid_unexpected: got %h, required no output", n_dn_data);
            end else begin
               exp_n = q_n.pop_front();
               if (n_dn_data !== exp_n)
                  $display("FAIL sb_noskid_data: got %h, required %h", n_dn_data, exp_n);
               else
                  n_pass++;
            end
         end
         if (n_up_valid && n_up_ready) q_n.push_back(n_up_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s_flush = 1'b0; s_up_valid = 1'b0; s_up_data = 16'h0; s_dn_ready = 1'b0;
      n_flush = 1'b0; n_up_valid = 1'b0; n_up_data = 16'h0; n_dn_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++; if (s_dn_valid !== 1'b0) $display("FAIL reset_dn_valid: got %b, required 0", s_dn_valid); else n_pass++;
      n_checks++; if (s_dn_data !== 16'h0000) $display("FAIL reset_dn_data: got %h, required 0000", s_dn_data); else n_pass++;
      n_checks++; if (s_up_ready !== 1'b1) $display("FAIL reset_up_ready: got %b, required 1", s_up_ready); else n_pass++;
      n_checks++; if (s_occ !== 2'd0) $display("FAIL reset_occupancy: got %0d, required 0", s_occ); else n_pass++;
      n_checks++; if (s_stall !== 4'd0) $display("FAIL reset_stall: got %0d, required 0", s_stall); else n_pass++;
      n_checks++; if (s_bubble !== 4'd0) $display("FAIL reset_bubble: got %0d, required 0", s_bubble); else n_pass++;
      n_checks++; if (n_dn_valid !== 1'b0 || n_up_ready !== 1'b1)
         $display("FAIL reset_noskid: got valid=%b ready=%b, required valid=0 ready=1", n_dn_valid, n_up_ready);
      else n_pass++;
   endtask

   task automatic test_stream();
      logic [15:0] vals [3];
      vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
      s_dn_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_up_valid = 1'b1;
         s_up_data  = vals[i];
         tick();
         n_checks++;
         if ({s_dn_valid, s_dn_data} !== {1'b1, vals[i]})
            $display("FAIL stream_latency_%0d: got valid=%b data=%h, required valid=1 data=%h", i, s_dn_valid, s_dn_data, vals[i]);
         else n_pass++;
      end
      s_up_valid = 1'b0;
      tick();
      n_checks++; if (s_dn_valid !== 1'b0) $display("FAIL stream_drained: got %b, required 0", s_dn_valid); else n_pass++;
      n_checks++; if (s_stall !== 4'd0) $display("FAIL stream_stall: got %0d, required 0", s_stall); else n_pass++;
   endtask

   task automatic test_skid_fill();
      s_dn_ready = 1'b0;
      s_up_valid = 1'b1; s_up_data = 16'hAAAA;
      tick();
      n_checks++; if (s_occ !== 2'd1 || s_up_ready !== 1'b1)
         $display("FAIL fill_one: got occ=%0d ready=%b, required occ=1 ready=1", s_occ, s_up_ready);
      else n_pass++;
      s_up_data = 16'hBBBB;
      tick();
      s_up_valid = 1'b0;
      n_checks++; if (s_occ !== 2'd2 || s_up_ready !== 1'b0)
         $display("FAIL fill_two: got occ=%0d ready=%b, required occ=2 ready=0", s_occ, s_up_ready);
      else n_pass++;
      tick();
      tick();
      n_checks++; if (s_dn_data !== 16'hAAAA) $display("FAIL fill_stable: got %h, required aaaa", s_dn_data); else n_pass++;
      n_checks++; if (s_stall !== 4'd3) $display("FAIL fill_stall_count: got %0d, required 3", s_stall); else n_pass++;
      s_dn_ready = 1'b1;
      tick();
      n_checks++; if (s_dn_data !== 16'hBBBB || s_occ !== 2'd1)
         $display("FAIL fill_drain_b: got data=%h occ=%0d, required data=bbbb occ=1", s_dn_data, s_occ);
      else n_pass++;
      tick();
      n_checks++; if (s_dn_valid !== 1'b0 || s_occ !== 2'd0)
         $display("FAIL fill_empty: got valid=%b occ=%0d, required valid=0 occ=0", s_dn_valid, s_occ);
      else n_pass++;
   endtask

   task automatic test_flush();
      s_dn_ready = 1'b0;
      s_up_valid = 1'b1; s_up_data = 16'hDDDD; tick();
      s_up_data = 16'hEEEE; tick();
      n_checks++; if (s_occ !== 2'd2) $display("FAIL flush_pre_occ: got %0d, required 2", s_occ); else n_pass++;
      s_flush = 1'b1; s_up_valid = 1'b1; s_up_data = 16'hCCCC;
      tick();
      s_flush = 1'b0; s_up_valid = 1'b0;
      n_checks++; if (s_dn_valid !== 1'b0 || s_occ !== 2'd0 || s_up_ready !== 1'b1 || s_dn_data !== 16'h0000)
         $display("FAIL flush_full: got valid=%b occ=%0d ready=%b data=%h, required 0/0/1/0000", s_dn_valid, s_occ, s_up_ready, s_dn_data);
      else n_pass++;
      s_dn_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (s_dn_valid !== 1'b0) $display("FAIL flush_no_reemit_%0d: got valid=%b data=%h, required valid=0", i, s_dn_valid, s_dn_data); else n_pass++;
      end
      // Flush while an up transfer is accepted into a half-full stage.
      s_dn_ready = 1'b0;
      s_up_valid = 1'b1; s_up_data = 16'h4444; tick();
      s_flush = 1'b1; s_up_data = 16'h5555; tick();
      s_flush = 1'b0; s_up_valid = 1'b0;
      n_checks++; if (s_dn_valid !== 1'b0 || s_occ !== 2'd0)
         $display("FAIL flush_busy_upxfer: got valid=%b occ=%0d, required valid=0 occ=0", s_dn_valid, s_occ);
      else n_pass++;
      s_dn_ready = 1'b1;
      s_up_valid = 1'b1; s_up_data = 16'h6666; tick();
      s_up_valid = 1'b0; s_flush = 1'b1; tick();
      s_flush = 1'b0;
      n_checks++; if (s_dn_valid !== 1'b0) $display("FAIL flush_with_dnxfer: got %b, required 0", s_dn_valid); else n_pass++;
   endtask

   task automatic test_counters();
      s_dn_ready = 1'b0;
      s_up_valid = 1'b1; s_up_data = 16'h1234; tick();
      s_up_valid = 1'b0;
      repeat (20) tick();
      n_checks++; if (s_stall !== 4'hF) $display("FAIL stall_saturate: got %h, required f", s_stall); else n_pass++;
      s_flush = 1'b1; tick();
      s_flush = 1'b0;
      n_checks++; if (s_stall !== 4'hF) $display("FAIL stall_kept_on_flush: got %h, required f", s_stall); else n_pass++;
      rst = 1'b1; tick();
      rst = 1'b0;
      n_checks++; if (s_stall !== 4'h0 || s_bubble !== 4'h0)
         $display("FAIL counters_cleared: got stall=%h bubble=%h, required 0/0", s_stall, s_bubble);
      else n_pass++;
      s_dn_ready = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         n_checks++;
         if (s_bubble !== ((k > 15) ? 4'hF : 4'(k)))
            $display("FAIL bubble_count_%0d: got %h, required %h", k, s_bubble, (k > 15) ? 4'hF : 4'(k));
         else n_pass++;
      end
   endtask

   task automatic test_random_noskid();
      logic acc;
      mon_n_en   = 1'b1;
      n_up_valid = 1'b0;
      n_dn_ready = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         acc = n_up_valid && n_up_ready;
         @(posedge clk);
         #1;
         n_dn_ready = ($urandom_range(0, 3) != 0);
         if (!n_up_valid || acc) begin
            n_up_valid = ($urandom_range(0, 1) == 1);
            n_up_data  = 16'($urandom);
         end
      end
      @(negedge clk);
      acc = n_up_valid && n_up_ready;
      @(posedge clk);
      #1;
      n_dn_ready = 1'b1;
      if (!acc && n_up_valid) begin
         @(negedge clk);
         @(posedge clk);
         #1;
      end
      n_up_valid = 1'b0;
      repeat (4) tick();
      mon_n_en = 1'b0;
      n_checks++; if (q_n.size() != 0 || n_dn_valid !== 1'b0)
         $display("FAIL noskid_drain: got %0d pending valid=%b, required 0 pending valid=0", q_n.size(), n_dn_valid);
      else n_pass++;
      n_checks++; if (n_delivered < 1000) $display("FAIL noskid_activity: got %0d transfers, required >= 1000", n_delivered); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid_fill();
      test_flush();
      test_counters();
      test_random_noskid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
